// File: rtl/alu_operand_decode.sv
// alu_operand_decode
//
// Decode/issue stage in front of the ALU. Takes one RV32I instruction per
// valid/ready handshake, reads its source operands from a 32x32 register
// file, and issues a registered {in_1, in_2, operation} triple plus
// destination info through a single-entry output register.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   in_valid/ready  - upstream handshake; in_instr/in_pc carry the instruction
//   wb_en/addr/data - register-file write port (write-first into the decode)
//   out_valid/ready - downstream handshake
//   out_in_1/2      - ALU operands
//   out_operation   - ALU op code (ERR = 15 for illegal encodings)
//   out_rd/rd_we    - destination register and its write enable
//   out_illegal     - decode failed
module alu_operand_decode #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [31:0]     in_pc,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_in_1,
    output logic [XLEN-1:0] out_in_2,
    output logic [3:0]      out_operation,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_illegal
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_EQL  = 4'd10;
    localparam logic [3:0] OP_NEQ  = 4'd11;
    localparam logic [3:0] OP_GTE  = 4'd12;
    localparam logic [3:0] OP_GTEU = 4'd13;
    localparam logic [3:0] OP_ERR  = 4'd15;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Shared funct3 -> ALU op mapping for OP and OP-IMM (base funct7).
    function automatic logic [3:0] alu_map(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'd0:    op = OP_ADD;
            3'd1:    op = OP_SLL;
            3'd2:    op = OP_SLT;
            3'd3:    op = OP_SLTU;
            3'd4:    op = OP_XOR;
            3'd5:    op = OP_SRL;
            3'd6:    op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

    // ------------------------------------------------------------------
    // Register file. Each entry is its own register so the whole file can
    // be cleared by reset. Writes to x0 are dropped, so entry 0 stays 0.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rf_reg [0:31];
    logic            accept;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rf
            always_ff @(posedge clk) begin
                if (rst) begin
                    rf_reg[gi] <= '0;
                end else if (wb_en && wb_addr == 5'(gi) && wb_addr != 5'd0) begin
                    rf_reg[gi] <= wb_data;
                end
            end
        end
    endgenerate

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1, rs2, rd;
    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    logic [31:0] imm_i, imm_s, imm_u;
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_u = {in_instr[31:12], 12'b0};

    // Write-first bypass: a same-cycle writeback to a source register wins
    // over the stored value (the stored value only updates at the edge).
    logic [XLEN-1:0] rs1_val, rs2_val;
    assign rs1_val = (wb_en && wb_addr == rs1 && rs1 != 5'd0) ? wb_data : rf_reg[rs1];
    assign rs2_val = (wb_en && wb_addr == rs2 && rs2 != 5'd0) ? wb_data : rf_reg[rs2];

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [XLEN-1:0] dec_in_1, dec_in_2;
    logic [3:0]      dec_op;
    logic [4:0]      dec_rd;
    logic            dec_we, dec_ill;

    always_comb begin
        dec_in_1 = '0;
        dec_in_2 = '0;
        dec_op   = OP_ADD;
        dec_rd   = '0;
        dec_we   = 1'b0;
        dec_ill  = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_in_1 = rs1_val;
                dec_in_2 = rs2_val;
                dec_rd   = rd;
                dec_we   = 1'b1;
                if (funct7 == F7_BASE)                    dec_op  = alu_map(funct3);
                else if (funct7 == F7_ALT && funct3 == 3'd0) dec_op  = OP_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'd5) dec_op  = OP_SRA;
                else                                      dec_ill = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_in_1 = rs1_val;
                dec_rd   = rd;
                dec_we   = 1'b1;
                if (funct3 == 3'd1 || funct3 == 3'd5) begin
                    // Shift-immediate: shamt only, funct7 field qualifies the form
                    dec_in_2 = {27'b0, in_instr[24:20]};
                    if (funct7 != F7_BASE && funct7 != F7_ALT) dec_ill = 1'b1;
                    else if (funct3 == 3'd5 && in_instr[30])   dec_op  = OP_SRA;
                    else                                       dec_op  = alu_map(funct3);
                end else begin
                    dec_in_2 = imm_i;
                    dec_op   = alu_map(funct3);
                end
            end
            OPC_LUI: begin
                dec_in_2 = imm_u;
                dec_rd   = rd;
                dec_we   = 1'b1;
            end
            OPC_AUIPC: begin
                dec_in_1 = in_pc;
                dec_in_2 = imm_u;
                dec_rd   = rd;
                dec_we   = 1'b1;
            end
            OPC_LOAD: begin
                dec_in_1 = rs1_val;
                dec_in_2 = imm_i;
                dec_rd   = rd;
                dec_we   = 1'b1;
            end
            OPC_STORE: begin
                dec_in_1 = rs1_val;
                dec_in_2 = imm_s;
            end
            OPC_BRANCH: begin
                dec_in_1 = rs1_val;
                dec_in_2 = rs2_val;
                case (funct3)
                    3'd0:    dec_op  = OP_EQL;
                    3'd1:    dec_op  = OP_NEQ;
                    3'd4:    dec_op  = OP_SLT;
                    3'd5:    dec_op  = OP_GTE;
                    3'd6:    dec_op  = OP_SLTU;
                    3'd7:    dec_op  = OP_GTEU;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal encodings issue a clean, inert bundle.
        if (dec_ill) begin
            dec_in_1 = '0;
            dec_in_2 = '0;
            dec_op   = OP_ERR;
            dec_rd   = '0;
            dec_we   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Issue register
    // ------------------------------------------------------------------
    logic            valid_reg;
    logic [XLEN-1:0] in_1_reg, in_2_reg;
    logic [3:0]      op_reg;
    logic [4:0]      rd_reg;
    logic            rd_we_reg, ill_reg;

    assign in_ready = !valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            in_1_reg  <= '0;
            in_2_reg  <= '0;
            op_reg    <= '0;
            rd_reg    <= '0;
            rd_we_reg <= 1'b0;
            ill_reg   <= 1'b0;
        end else if (accept) begin
            valid_reg <= 1'b1;
            in_1_reg  <= dec_in_1;
            in_2_reg  <= dec_in_2;
            op_reg    <= dec_op;
            rd_reg    <= dec_rd;
            rd_we_reg <= dec_we;
            ill_reg   <= dec_ill;
        end else if (out_ready) begin
            // Consumed with nothing behind it; payload fields simply hold.
            valid_reg <= 1'b0;
        end
    end

    assign out_valid     = valid_reg;
    assign out_in_1      = in_1_reg;
    assign out_in_2      = in_2_reg;
    assign out_operation = op_reg;
    assign out_rd        = rd_reg;
    assign out_rd_we     = rd_we_reg;
    assign out_illegal   = ill_reg;

endmodule
